// File: rtl/minsoc_reset_manager.sv
// Sequenced reset generator for the SoC.
// Holds the Wishbone fabric and the CPU in reset until the clock source is
// locked. It then releases the bus first and the CPU CPU_DELAY cycles later.
// A debounced push-button, a soft-reset request or a loss of lock restarts
// the sequence. The cause of the most recent reset is kept on rst_cause_o.
//
// Ports:
//   clk_i       system clock (divided clock-manager output)
//   rst_n_i     synchronous active-low power-on reset
//   locked_i    clock-source lock, asynchronous
//   btn_i       raw reset push-button, asynchronous
//   soft_rst_i  soft-reset request, synchronous to clk_i, level-sampled
//   wb_rst_o    active-high Wishbone/peripheral reset
//   cpu_rst_o   active-high CPU reset
//   rst_cause_o 00 power-on, 01 lock loss, 10 button, 11 soft
//   busy_o      high whenever the sequencer is not in RUN
module minsoc_reset_manager #(
    parameter int unsigned HOLD_CYCLES     = 16,
    parameter int unsigned CPU_DELAY       = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1024,
    parameter bit          BTN_ACTIVE      = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       locked_i,
    input  logic       btn_i,
    input  logic       soft_rst_i,
    output logic       wb_rst_o,
    output logic       cpu_rst_o,
    output logic [1:0] rst_cause_o,
    output logic       busy_o
);

    localparam logic [1:0] StWaitLock = 2'd0;
    localparam logic [1:0] StHold     = 2'd1;
    localparam logic [1:0] StCpuWait  = 2'd2;
    localparam logic [1:0] StRun      = 2'd3;

    localparam logic [1:0] CausePor  = 2'b00;
    localparam logic [1:0] CauseLock = 2'b01;
    localparam logic [1:0] CauseBtn  = 2'b10;
    localparam logic [1:0] CauseSoft = 2'b11;

    localparam logic [15:0] HoldLast = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] CpuLast  = 16'(CPU_DELAY - 1);
    localparam logic [15:0] DbLast   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic        BtnIdle  = ~BTN_ACTIVE;

    // Input conditioning
    logic        lock_meta_q, lock_sync_q;
    logic        btn_meta_q, btn_sync_q;
    logic        btn_stable_q;
    logic [15:0] db_cnt_q;
    logic        btn_pressed;

    // Button flops start at the idle level so reset never looks like a press.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            btn_meta_q   <= BtnIdle;
            btn_sync_q   <= BtnIdle;
            btn_stable_q <= BtnIdle;
            db_cnt_q     <= 16'd0;
        end else begin
            lock_meta_q <= locked_i;
            lock_sync_q <= lock_meta_q;
            btn_meta_q  <= btn_i;
            btn_sync_q  <= btn_meta_q;
            // Count only while a new level is pending; any return to the
            // accepted level discards the partial count.
            if (btn_sync_q == btn_stable_q) begin
                db_cnt_q <= 16'd0;
            end else if (db_cnt_q == DbLast) begin
                btn_stable_q <= btn_sync_q;
                db_cnt_q     <= 16'd0;
            end else begin
                db_cnt_q <= db_cnt_q + 16'd1;
            end
        end
    end

    assign btn_pressed = (btn_stable_q == BTN_ACTIVE);

    // Sequencer
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic        wb_rst_q, wb_rst_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_d   = cause_q;
        wb_rst_d  = wb_rst_q;
        cpu_rst_d = cpu_rst_q;
        busy_d    = busy_q;
        case (state_q)
            StWaitLock: begin
                wb_rst_d  = 1'b1;
                cpu_rst_d = 1'b1;
                busy_d    = 1'b1;
                if (lock_sync_q) begin
                    state_d = StHold;
                    cnt_d   = 16'd0;
                end
            end
            StHold: begin
                wb_rst_d  = 1'b1;
                cpu_rst_d = 1'b1;
                busy_d    = 1'b1;
                // Events inside HOLD only restart the hold; cause is kept.
                if (!lock_sync_q) begin
                    state_d = StWaitLock;
                end else if (btn_pressed || soft_rst_i) begin
                    cnt_d = 16'd0;
                end else if (cnt_q == HoldLast) begin
                    state_d  = StCpuWait;
                    cnt_d    = 16'd0;
                    wb_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCpuWait, StRun: begin
                if (!lock_sync_q || btn_pressed || soft_rst_i) begin
                    wb_rst_d  = 1'b1;
                    cpu_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = 16'd0;
                    if (!lock_sync_q) begin
                        state_d = StWaitLock;
                        cause_d = CauseLock;
                    end else if (btn_pressed) begin
                        state_d = StHold;
                        cause_d = CauseBtn;
                    end else begin
                        state_d = StHold;
                        cause_d = CauseSoft;
                    end
                end else if (state_q == StCpuWait) begin
                    if (cnt_q == CpuLast) begin
                        state_d   = StRun;
                        cpu_rst_d = 1'b0;
                        busy_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StWaitLock;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= StWaitLock;
            cnt_q     <= 16'd0;
            cause_q   <= CausePor;
            wb_rst_q  <= 1'b1;
            cpu_rst_q <= 1'b1;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            wb_rst_q  <= wb_rst_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_rst_o    = wb_rst_q;
    assign cpu_rst_o   = cpu_rst_q;
    assign rst_cause_o = cause_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_minsoc_reset_manager.sv
// Directed testbench for minsoc_reset_manager (HOLD 16, CPU_DELAY 4, DEBOUNCE 8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_minsoc_reset_manager;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       locked_i;
    logic       btn_i;
    logic       soft_rst_i;
    logic       wb_rst_o;
    logic       cpu_rst_o;
    logic [1:0] rst_cause_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    minsoc_reset_manager #(
        .HOLD_CYCLES    (16),
        .CPU_DELAY      (4),
        .DEBOUNCE_CYCLES(8),
        .BTN_ACTIVE     (1'b1)
    ) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .locked_i   (locked_i),
        .btn_i      (btn_i),
        .soft_rst_i (soft_rst_i),
        .wb_rst_o   (wb_rst_o),
        .cpu_rst_o  (cpu_rst_o),
        .rst_cause_o(rst_cause_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Edges until the selected reset (0 = wb, 1 = cpu) reaches lvl, capped at limit.
    task automatic wait_for(input int sel, input logic lvl, input int limit, output int n);
        n = 0;
        while ((((sel == 0) ? wb_rst_o : cpu_rst_o) !== lvl) && (n < limit)) begin
            tick(1);
            n++;
        end
    endtask

    // CPU must never run while the bus is still in reset.
    always @(negedge clk_i) begin
        if (mon_en) check("order", {31'd0, wb_rst_o & ~cpu_rst_o}, 32'd0);
    end

    initial begin
        int n;
        int bad;

        // Power-on reset with lock present
        rst_n_i    = 1'b0;
        locked_i   = 1'b1;
        btn_i      = 1'b0;
        soft_rst_i = 1'b0;
        tick(3);
        check("por_wb", wb_rst_o, 1);
        check("por_cpu", cpu_rst_o, 1);
        check("por_busy", busy_o, 1);
        check("por_cause", rst_cause_o, 0);
        mon_en  = 1'b1;
        rst_n_i = 1'b1;
        // 2 sync edges + 1 edge into HOLD + 16 hold edges
        wait_for(0, 1'b0, 100, n);
        check("por_wb_lat", n, 19);
        check("por_cpu_busy", busy_o, 1);
        wait_for(1, 1'b0, 100, n);
        check("por_cpu_lat", n, 4);
        check("run_busy", busy_o, 0);
        check("run_cause", rst_cause_o, 0);

        // No lock after reset
        rst_n_i  = 1'b0;
        locked_i = 1'b0;
        tick(2);
        rst_n_i = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (!wb_rst_o || !cpu_rst_o) bad++;
        end
        check("nolock_held", bad, 0);
        locked_i = 1'b1;
        wait_for(0, 1'b0, 100, n);
        check("late_lock_wb_lat", n, 19);
        wait_for(1, 1'b0, 100, n);
        check("late_lock_cpu_lat", n, 4);

        // One-cycle lock drop in RUN
        locked_i = 1'b0;
        tick(1);
        locked_i = 1'b1;
        wait_for(0, 1'b1, 20, n);
        check("lockdrop_lat", n + 1, 3);
        check("lockdrop_cpu", cpu_rst_o, 1);
        check("lockdrop_cause", rst_cause_o, 1);
        // Lock back: one more WAIT_LOCK edge, HOLD entry, then 16 hold edges
        wait_for(0, 1'b0, 100, n);
        check("lockdrop_wb_lat", n, 17);
        wait_for(1, 1'b0, 100, n);
        check("lockdrop_cpu_lat", n, 4);

        // Button glitch shorter than the debounce window
        btn_i = 1'b1;
        tick(5);
        btn_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (wb_rst_o || cpu_rst_o) bad++;
        end
        check("glitch_ignored", bad, 0);
        check("glitch_cause", rst_cause_o, 1);

        // Button held 20 cycles: 2 sync + 8 debounce + 1 FSM edge
        btn_i = 1'b1;
        wait_for(0, 1'b1, 19, n);
        check("btn_assert_lat", n, 11);
        check("btn_cpu", cpu_rst_o, 1);
        check("btn_cause", rst_cause_o, 2);
        tick(20 - n);
        btn_i = 1'b0;
        // Release accepted 10 edges later, then 16 hold edges
        wait_for(0, 1'b0, 100, n);
        check("btn_release_lat", n, 26);
        wait_for(1, 1'b0, 100, n);
        check("btn_cpu_lat", n, 4);

        // Soft reset pulse, then a second pulse at hold count 10
        soft_rst_i = 1'b1;
        tick(1);
        soft_rst_i = 1'b0;
        check("soft_wb", wb_rst_o, 1);
        check("soft_cpu", cpu_rst_o, 1);
        check("soft_cause", rst_cause_o, 3);
        tick(10);
        check("soft_still_hold", wb_rst_o, 1);
        soft_rst_i = 1'b1;
        tick(1);
        soft_rst_i = 1'b0;
        wait_for(0, 1'b0, 100, n);
        check("soft_restart_lat", n, 16);
        wait_for(1, 1'b0, 100, n);
        check("soft_cpu_lat", n, 4);

        // Lock loss, button and soft all reach the sequencer on the same edge
        btn_i = 1'b1;
        tick(8);
        locked_i = 1'b0;
        tick(2);
        soft_rst_i = 1'b1;
        check("simul_pre_wb", wb_rst_o, 0);
        tick(1);
        soft_rst_i = 1'b0;
        check("simul_wb", wb_rst_o, 1);
        check("simul_cpu", cpu_rst_o, 1);
        check("simul_cause", rst_cause_o, 1);
        btn_i    = 1'b0;
        locked_i = 1'b1;
        wait_for(0, 1'b0, 200, n);
        check("simul_recover_wb", wb_rst_o, 0);
        check("simul_recover_cause", rst_cause_o, 1);

        // Power-on reset in the middle of CPU_WAIT
        check("cpuwait_busy", busy_o, 1);
        tick(1);
        check("cpuwait_cpu", cpu_rst_o, 1);
        rst_n_i = 1'b0;
        tick(1);
        check("midrst_wb", wb_rst_o, 1);
        check("midrst_cpu", cpu_rst_o, 1);
        check("midrst_busy", busy_o, 1);
        check("midrst_cause", rst_cause_o, 0);
        rst_n_i = 1'b1;
        tick(2);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
